// File: rtl/mini_alu_pkg.sv
// Purpose: shared defaults and state encoding for the mini-ALU streaming stages.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default sample/operand width, default burst-length/index width,
//           and the scan FSM state type (IDLE / ACCUM / DONE).
package mini_alu_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LEN_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } scan_state_t;

endpackage

// File: rtl/min8_scan_ctrl.sv
// Purpose: control FSM for min8_scan; owns state, burst length and sample count.
// Latency: moves to DONE on the same edge the last sample is accepted.
// Backpressure: in_ready only in ACCUM; DONE holds until out_ready.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, len        burst request (honoured only in IDLE with len != 0)
//   in_valid          upstream sample valid
//   out_ready         downstream result accept
//   in_ready          block can take a sample (ACCUM)
//   out_valid         result presented (DONE)
//   busy              ACCUM or DONE
//   accept            sample handshake completes this cycle
//   first             next accepted sample is the first of the burst
//   count             0-based index of the next sample to be accepted
module min8_scan_ctrl
  import mini_alu_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             busy,
  output logic             accept,
  output logic             first,
  output logic [LEN_W-1:0] count
);

  scan_state_t      state;
  scan_state_t      state_nxt;
  logic [LEN_W-1:0] len_reg;
  logic             load;
  logic             last;

  // len_reg is never 0 while in ACCUM, so len_reg-1 cannot underflow there.
  assign last = (count == (len_reg - LEN_W'(1)));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && (len != '0)) begin
          load      = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign accept = in_valid && in_ready;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      len_reg <= '0;
      count   <= '0;
      first   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        len_reg <= len;
        count   <= '0;
        first   <= 1'b1;
      end else if (accept) begin
        // Max burst is 2^LEN_W-1, so the post-increment count always fits.
        count <= count + LEN_W'(1);
        first <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/min8_scan.sv
// Purpose: streaming minimum finder over a 1..2^LEN_W-1 sample burst, using an
//          external less-than comparator; reports min value and first index.
// Latency: out_valid rises one cycle after the last sample is accepted.
// Backpressure: one sample/cycle in ACCUM; result held in DONE until out_ready.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start, len              burst request and length (len 0 is ignored)
//   in_valid/in_ready/in_data   sample handshake
//   cmp_a, cmp_b, cmp_lt    comparator operands (sample, running min) and result
//   out_valid/out_ready     result handshake
//   out_min, out_idx        burst minimum and index of its first occurrence
//   busy                    burst in progress or result pending
module min8_scan
  import mini_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_lt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [LEN_W-1:0] out_idx,
  output logic             busy
);

  logic             accept;
  logic             first;
  logic [LEN_W-1:0] count;
  logic [WIDTH-1:0] min_reg;
  logic [LEN_W-1:0] idx_reg;
  logic             take;

  min8_scan_ctrl #(
    .LEN_W(LEN_W)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .busy     (busy),
    .accept   (accept),
    .first    (first),
    .count    (count)
  );

  // The comparator sits outside this block; it sees the live sample against
  // the running minimum and answers in the same cycle.
  assign cmp_a = in_data;
  assign cmp_b = min_reg;

  // First sample always seeds the minimum (min_reg is stale from the last
  // burst). Strict less-than means ties keep the earlier index.
  assign take = accept && (first || cmp_lt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_reg <= '0;
      idx_reg <= '0;
    end else if (take) begin
      min_reg <= in_data;
      idx_reg <= count;
    end
  end

  // Result registers are only written on accepts, so they stay stable in DONE
  // and keep the last result after returning to IDLE.
  assign out_min = min_reg;
  assign out_idx = idx_reg;

endmodule
